// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data-memory signals of the load/store unit
// master is the LSU view; slave is the core plus data-memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit for a word-addressed 32-bit data memory
// Sub-word stores are read-modify-write; all error checks happen at acceptance.
module load_store_unit #(
  parameter int MEM_WORDS = 1000
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;
  logic [31:0] lat_wdata;

  logic [31:0] req_index;
  logic        req_misaligned;
  logic        req_illegal;
  logic        req_out_of_range;
  logic        req_err;

  assign req_index        = {2'b00, bus.req_addr[31:2]};
  assign req_out_of_range = (req_index >= MEM_WORDS_W);
  assign req_err          = req_misaligned | req_illegal | req_out_of_range;

  always_comb begin
    req_misaligned = 1'b0;
    req_illegal    = 1'b0;
    case (bus.req_funct3)
      3'b000: req_illegal = 1'b0;
      3'b001: req_misaligned = bus.req_addr[0];
      3'b010: req_misaligned = (bus.req_addr[1:0] != 2'b00);
      3'b100: req_illegal = bus.req_we;
      3'b101: begin
        req_illegal    = bus.req_we;
        req_misaligned = bus.req_addr[0];
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Load lane extraction from the word presented during LD.
  logic [31:0] load_lane;
  logic [31:0] load_data;

  assign load_lane = bus.mem_rdata >> {lat_offset, 3'b000};

  always_comb begin
    load_data = load_lane;
    case (lat_funct3)
      3'b000:  load_data = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_data = {24'h000000, load_lane[7:0]};
      3'b101:  load_data = {16'h0000, load_lane[15:0]};
      default: load_data = load_lane;
    endcase
  end

  // Only SB and SH reach RMW, so funct3[0] alone selects halfword versus byte lane.
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;

  assign lane_shift  = lat_funct3[0] ? {lat_offset[1], 4'b0000} : {lat_offset, 3'b000};
  assign lane_mask   = (lat_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
  assign merged_word = (bus.mem_rdata & ~lane_mask) | ((lat_wdata << lane_shift) & lane_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_we         <= 1'b0;
      lat_funct3     <= 3'b000;
      lat_offset     <= 2'b00;
      lat_wdata      <= 32'h0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.resp_err   <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we        <= bus.req_we;
            lat_funct3    <= bus.req_funct3;
            lat_offset    <= bus.req_addr[1:0];
            lat_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else if (!bus.req_we) begin
              state        <= LD;
              bus.mem_read <= 1'b1;
              bus.mem_addr <= req_index;
            end else if (bus.req_funct3 == 3'b010) begin
              state         <= ST;
              bus.mem_write <= 1'b1;
              bus.mem_addr  <= req_index;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state        <= RMW_RD;
              bus.mem_read <= 1'b1;
              bus.mem_addr <= req_index;
            end
          end
        end
        LD: begin
          state          <= RESP;
          bus.mem_read   <= 1'b0;
          bus.mem_addr   <= 32'h0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= lat_we ? 32'h0 : load_data;
        end
        ST: begin
          state          <= RESP;
          bus.mem_write  <= 1'b0;
          bus.mem_wdata  <= 32'h0;
          bus.mem_addr   <= 32'h0;
          bus.resp_valid <= 1'b1;
        end
        RMW_RD: begin
          // mem_addr is kept so the write lands on the word just read.
          state         <= RMW_WR;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b1;
          bus.mem_wdata <= merged_word;
        end
        RMW_WR: begin
          state          <= RESP;
          bus.mem_write  <= 1'b0;
          bus.mem_wdata  <= 32'h0;
          bus.mem_addr   <= 32'h0;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
